// File: rtl/pc_fetch_queue_pkg.sv
// Shared fetch front-end constants and the branch-handling decision helper.
package pc_fetch_queue_pkg;

  localparam int          ADDR_W_DEF       = 32;
  localparam int          DATA_W_DEF       = 32;
  localparam logic [31:0] RESET_VECTOR_DEF = 32'h3000_0000;
  localparam int          INST_BYTES_DEF   = 4;

  localparam logic ENABLE     = 1'b1;
  localparam logic DISABLE    = 1'b0;
  localparam logic BRANCH     = 1'b1;
  localparam logic NOT_BRANCH = 1'b0;

  typedef enum logic [2:0] {
    BR_NONE      = 3'd0,
    BR_CLEAR     = 3'd1,
    BR_KEEP_HEAD = 3'd2,
    BR_KEEP_RESP = 3'd3,
    BR_REDIRECT  = 3'd4
  } branch_act_e;

  // Picks which fetched word (if any) survives as the delay slot.
  function automatic branch_act_e branch_action(input logic branch,
                                                input logic delay_slot,
                                                input logic remain_nz,
                                                input logic pending);
    branch_act_e act;
    act = BR_NONE;
    if (branch == BRANCH) begin
      if (!delay_slot)    act = BR_CLEAR;
      else if (remain_nz) act = BR_KEEP_HEAD;
      else if (pending)   act = BR_KEEP_RESP;
      else                act = BR_REDIRECT;
    end
    return act;
  endfunction

endpackage

// File: rtl/pc_fetch_queue_fetch_fifo.sv
// Show-ahead FIFO of fetched {pc, inst} entries with clear and truncate-to-head.
module fetch_fifo
  import pc_fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_all,
  input  logic             keep_head,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             head_valid,
  output logic [WIDTH-1:0] head_data,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr_nxt;
  logic             wr_en;

  assign rd_ptr_nxt = rd_ptr + PTR_W'(pop);
  assign head_valid = (count != '0);
  assign head_data  = mem[rd_ptr];
  assign wr_en      = push & ~clear_all & ~keep_head;

  always_ff @(posedge clk) begin
    if (!rst || clear_all) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= rd_ptr_nxt;
      if (keep_head) begin
        // Only the oldest surviving entry stays; caller guarantees one exists.
        wr_ptr <= rd_ptr_nxt + PTR_W'(1);
        count  <= CNT_W'(1);
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        count <= count + CNT_W'(push) - CNT_W'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= push_data;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(wr_en && !pop && (count == CNT_W'(DEPTH))));

endmodule

// File: rtl/pc_fetch_queue.sv
// Instruction fetch front end: PC generation, 1-cycle imem interface, credit-based
// decoupling queue toward ID, with flush and branch (optional delay slot) handling.
module pc_fetch_queue
  import pc_fetch_queue_pkg::*;
#(
  parameter int                ADDR_W       = ADDR_W_DEF,
  parameter int                DATA_W       = DATA_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(RESET_VECTOR_DEF),
  parameter int                INST_BYTES   = INST_BYTES_DEF,
  parameter int                DEPTH        = 4,
  parameter int                DELAY_SLOT   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] new_pc_i,
  input  logic              branch_flag_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  output logic              imem_ce_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic [DATA_W-1:0] imem_rdata_i,
  output logic              id_valid_o,
  output logic [DATA_W-1:0] id_inst_o,
  output logic [ADDR_W-1:0] id_pc_o,
  input  logic              id_ready_i
);

  localparam int              CNT_W  = $clog2(DEPTH) + 1;
  localparam int              ENT_W  = ADDR_W + DATA_W;
  localparam logic [CNT_W:0]  CREDIT = (CNT_W + 1)'(DEPTH);

  logic              run_q;
  logic              pending;
  logic              redir_valid;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] req_pc;
  logic [ADDR_W-1:0] redir_target;

  logic [CNT_W-1:0]  count;
  logic              head_valid;
  logic [ENT_W-1:0]  head_data;
  logic              pop;
  logic              push;
  logic              issue;
  logic              clear_all;
  logic              keep_head;
  logic              remain_nz;
  logic              squash;
  branch_act_e       br_act;

  assign pop       = head_valid & id_ready_i;
  assign remain_nz = ((count - CNT_W'(pop)) != '0);
  assign br_act    = flush_i ? BR_NONE
                   : branch_action(branch_flag_i, DELAY_SLOT != 0, remain_nz, pending);

  // Credit counts the in-flight response so a push can never find the queue full.
  assign issue = run_q & ~flush_i & ~branch_flag_i
               & (({1'b0, count} + (CNT_W + 1)'(pending)) < CREDIT);

  assign squash    = flush_i | (br_act == BR_CLEAR) | (br_act == BR_KEEP_HEAD);
  assign push      = pending & ~squash;
  assign clear_all = flush_i | (br_act == BR_CLEAR);
  assign keep_head = (br_act == BR_KEEP_HEAD);

  assign imem_ce_o   = issue;
  assign imem_addr_o = pc;
  assign id_valid_o  = head_valid;
  assign id_inst_o   = head_valid ? head_data[DATA_W-1:0]     : '0;
  assign id_pc_o     = head_valid ? head_data[ENT_W-1:DATA_W] : '0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      run_q        <= DISABLE;
      pending      <= 1'b0;
      redir_valid  <= 1'b0;
      pc           <= RESET_VECTOR;
      req_pc       <= '0;
      redir_target <= '0;
    end else begin
      run_q   <= ENABLE;
      pending <= issue;
      if (issue) req_pc <= pc;

      if (flush_i) begin
        pc          <= new_pc_i;
        redir_valid <= 1'b0;
      end else if (br_act == BR_REDIRECT) begin
        // Delay slot not fetched yet: fetch pc once more, then jump.
        redir_valid  <= 1'b1;
        redir_target <= branch_target_i;
      end else if (branch_flag_i) begin
        pc <= branch_target_i;
      end else if (issue) begin
        pc          <= redir_valid ? redir_target : pc + ADDR_W'(INST_BYTES);
        redir_valid <= 1'b0;
      end
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENT_W),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .clear_all  (clear_all),
    .keep_head  (keep_head),
    .push       (push),
    .push_data  ({req_pc, imem_rdata_i}),
    .pop        (pop),
    .head_valid (head_valid),
    .head_data  (head_data),
    .count      (count)
  );

  a_no_branch_in_redirect: assert property (@(posedge clk) disable iff (!rst)
    !(branch_flag_i && !flush_i && redir_valid));

endmodule

// File: tb/tb_pc_fetch_queue.sv
// Bench for pc_fetch_queue: startup vector table, scoreboard of delivered words,
// and directed branch / flush / reset sequences on DELAY_SLOT=1 and =0 instances.
module tb_pc_fetch_queue;

  logic        clk;
  logic        rst;
  logic        flush;
  logic [31:0] new_pc;
  logic        branch;
  logic [31:0] target;
  logic        ready;

  logic        ce1, valid1, ce0, valid0;
  logic [31:0] addr1, rdata1, inst1, pc1;
  logic [31:0] addr0, rdata0, inst0, pc0;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp1_q[$];
  logic [31:0] exp0_q[$];
  logic        sb0_en = 1'b1;

  localparam logic [31:0] RV = 32'h3000_0000;

  pc_fetch_queue #(.DELAY_SLOT(1)) dut (
    .clk(clk), .rst(rst), .flush_i(flush), .new_pc_i(new_pc),
    .branch_flag_i(branch), .branch_target_i(target),
    .imem_ce_o(ce1), .imem_addr_o(addr1), .imem_rdata_i(rdata1),
    .id_valid_o(valid1), .id_inst_o(inst1), .id_pc_o(pc1), .id_ready_i(ready)
  );

  pc_fetch_queue #(.DELAY_SLOT(0)) dut0 (
    .clk(clk), .rst(rst), .flush_i(flush), .new_pc_i(new_pc),
    .branch_flag_i(branch), .branch_target_i(target),
    .imem_ce_o(ce0), .imem_addr_o(addr0), .imem_rdata_i(rdata0),
    .id_valid_o(valid0), .id_inst_o(inst0), .id_pc_o(pc0), .id_ready_i(ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  always @(posedge clk) begin
    if (ce1) rdata1 <= inst_of(addr1);
    if (ce0) rdata0 <= inst_of(addr0);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic sb_pop1();
    logic [31:0] e;
    if (exp1_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL sb1_extra: got pc %h expected no delivery", pc1);
    end else begin
      e = exp1_q.pop_front();
      chk("sb1_pc", pc1, e);
      chk("sb1_inst", inst1, inst_of(e));
    end
  endtask

  task automatic sb_pop0();
    logic [31:0] e;
    if (exp0_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL sb0_extra: got pc %h expected no delivery", pc0);
    end else begin
      e = exp0_q.pop_front();
      chk("sb0_pc", pc0, e);
      chk("sb0_inst", inst0, inst_of(e));
    end
  endtask

  // One cycle: drive after the falling edge, let outputs settle, score any pop.
  task automatic drive(input logic r, input logic rdy, input logic fl, input logic [31:0] npc,
                       input logic br, input logic [31:0] tgt);
    @(negedge clk);
    rst = r; ready = rdy; flush = fl; new_pc = npc; branch = br; target = tgt;
    #1;
    if (valid1 && ready) sb_pop1();
    if (sb0_en && valid0 && ready) sb_pop0();
  endtask

  task automatic run(input int n, input logic rdy);
    for (int i = 0; i < n; i++) drive(1'b1, rdy, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic exp_both(input logic [31:0] p);
    exp1_q.push_back(p);
    exp0_q.push_back(p);
  endtask

  task automatic chk_drained(input string name);
    chk({name, "_q1_left"}, exp1_q.size(), 0);
    if (sb0_en) chk({name, "_q0_left"}, exp0_q.size(), 0);
  endtask

  typedef struct {
    logic        exp_ce;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int ce_cnt;

    vecs[0] = '{1'b0, RV,        1'b0, 32'h0};
    vecs[1] = '{1'b1, RV,        1'b0, 32'h0};
    vecs[2] = '{1'b1, RV + 4,    1'b0, 32'h0};
    vecs[3] = '{1'b1, RV + 8,    1'b1, RV};
    vecs[4] = '{1'b1, RV + 12,   1'b1, RV + 4};
    vecs[5] = '{1'b1, RV + 16,   1'b1, RV + 8};
    vecs[6] = '{1'b1, RV + 20,   1'b1, RV + 12};
    vecs[7] = '{1'b1, RV + 24,   1'b1, RV + 16};

    rst = 1'b0; ready = 1'b0; flush = 1'b0; new_pc = '0; branch = 1'b0; target = '0;
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);

    // Startup stream with ID always ready
    for (int i = 0; i < 5; i++) exp_both(RV + 32'(4 * i));
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      chk($sformatf("start%0d_ce", i), 32'(ce1), 32'(vecs[i].exp_ce));
      chk($sformatf("start%0d_addr", i), addr1, vecs[i].exp_addr);
      chk($sformatf("start%0d_valid", i), 32'(valid1), 32'(vecs[i].exp_valid));
      chk($sformatf("start%0d_pc", i), pc1, vecs[i].exp_pc);
      chk($sformatf("start%0d_inst", i), inst1,
          vecs[i].exp_valid ? inst_of(vecs[i].exp_pc) : 32'h0);
    end
    chk_drained("start");

    // ID stall: queue fills to DEPTH and fetch stops
    ce_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      run(1, 1'b0);
      ce_cnt += int'(ce1);
    end
    chk("stall_ce_count", ce_cnt, 2);
    chk("stall_ce_final", 32'(ce1), 0);
    chk("stall_head", pc1, RV + 20);
    for (int i = 0; i < 8; i++) exp_both(RV + 20 + 32'(4 * i));
    run(8, 1'b1);
    run(1, 1'b0);
    chk_drained("drain");

    // Branch popped from a full queue 0x100..0x10C
    drive(1'b1, 1'b0, 1'b1, 32'h100, 1'b0, 32'h0);
    chk("flush100_ce", 32'(ce1), 0);
    run(6, 1'b0);
    chk("full_head", pc1, 32'h100);
    chk("full_ce", 32'(ce1), 0);
    exp1_q.push_back(32'h100); exp1_q.push_back(32'h104);
    exp1_q.push_back(32'h200); exp1_q.push_back(32'h204); exp1_q.push_back(32'h208);
    exp0_q.push_back(32'h100);
    exp0_q.push_back(32'h200); exp0_q.push_back(32'h204); exp0_q.push_back(32'h208);
    drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h200);
    chk("br_ce", 32'(ce1), 0);
    run(1, 1'b1);
    chk("ds1_slot_head", pc1, 32'h104);
    chk("ds0_empty", 32'(valid0), 0);
    chk("ds0_fetch_target", addr0, 32'h200);
    run(4, 1'b1);
    run(2, 1'b0);
    chk_drained("branch");

    // Branch with empty queue and nothing pending: delay slot fetched first
    sb0_en = 1'b0;
    drive(1'b1, 1'b0, 1'b1, 32'h100, 1'b0, 32'h0);
    run(6, 1'b0);
    exp1_q.push_back(32'h100); exp1_q.push_back(32'h104);
    exp1_q.push_back(32'h104); exp1_q.push_back(32'h200);
    drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h104);
    drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h200);
    run(1, 1'b1);
    chk("redir_ce0", 32'(ce1), 1);
    chk("redir_addr0", addr1, 32'h104);
    run(1, 1'b1);
    chk("redir_ce1", 32'(ce1), 1);
    chk("redir_addr1", addr1, 32'h200);
    run(2, 1'b1);
    run(2, 1'b0);
    chk_drained("redir");

    // Flush together with branch, pending response and credit-full queue
    drive(1'b1, 1'b0, 1'b1, 32'h300, 1'b0, 32'h0);
    run(4, 1'b0);
    chk("pre_flush_addr", addr1, 32'h30C);
    exp1_q.push_back(32'h300);
    drive(1'b1, 1'b1, 1'b1, 32'h8000_0180, 1'b1, 32'h200);
    chk("flush_ce", 32'(ce1), 0);
    exp1_q.push_back(32'h8000_0180); exp1_q.push_back(32'h8000_0184);
    run(1, 1'b1);
    chk("flush_valid", 32'(valid1), 0);
    chk("flush_ce_next", 32'(ce1), 1);
    chk("flush_addr", addr1, 32'h8000_0180);
    run(3, 1'b1);
    run(2, 1'b0);
    chk_drained("flush");

    // One-cycle reset mid-stream with a response in flight
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    exp1_q.push_back(RV); exp1_q.push_back(RV + 4);
    run(1, 1'b1);
    chk("rst_ce", 32'(ce1), 0);
    chk("rst_valid", 32'(valid1), 0);
    chk("rst_pc", pc1, 0);
    chk("rst_inst", inst1, 0);
    chk("rst_addr", addr1, RV);
    run(1, 1'b1);
    chk("rst_first_ce", 32'(ce1), 1);
    chk("rst_first_addr", addr1, RV);
    chk("rst_no_stale", 32'(valid1), 0);
    run(1, 1'b1);
    chk("rst_fill_valid", 32'(valid1), 0);
    run(2, 1'b1);
    run(2, 1'b0);
    chk_drained("reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_fetch_queue.md
Name: pc_fetch_queue

Overview:
- Next-generation instruction-fetch front end: parametrised PC generator plus decoupling queue of fetched instructions.
- Drives a synchronous instruction memory (fixed 1-cycle read latency), captures returned words with their PCs into a DEPTH-entry FIFO, and presents them to ID over a valid/ready handshake.
- Handles exception flush, branch redirect with optional MIPS delay slot, and back-pressure by credit, so fetch keeps running while ID stalls.

Parameters:
- ADDR_W, 32, PC / instruction address width
- DATA_W, 32, instruction word width
- RESET_VECTOR, 32'h30000000, first fetch address after reset
- INST_BYTES, 4, PC increment per sequential fetch
- DEPTH, 4, queue entries; power of 2, at least 2
- DELAY_SLOT, 1, 1 = instruction after a branch is preserved; 0 = no delay slot

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset; synchronous, active-low (rst==0 resets on the clock edge)
- flush_i  in  1  exception flush from CTRL; highest priority
- new_pc_i  in  ADDR_W  exception handler address, used when flush_i=1
- branch_flag_i  in  1  taken branch, asserted by ID in the cycle it pops the branch
- branch_target_i  in  ADDR_W  branch target
- imem_ce_o  out  1  instruction memory read enable
- imem_addr_o  out  ADDR_W  read address
- imem_rdata_i  in  DATA_W  read data, valid the cycle after imem_ce_o=1
- id_valid_o  out  1  queue head valid
- id_inst_o  out  DATA_W  head instruction (show-ahead)
- id_pc_o  out  ADDR_W  head PC
- id_ready_i  in  1  ID accepts head; pop = id_valid_o & id_ready_i

Behaviour:
- Reset (rst==0 at edge):
  - pc=RESET_VECTOR; run_q=0; queue empty; pending=0; redir_valid=0.
  - Outputs: imem_ce_o=0, id_valid_o=0, id_inst_o=0, id_pc_o=0. imem_addr_o shows pc.
  - Reset mid-operation discards everything, including any in-flight response.
- run_q is set on the first edge with rst==1. The first request therefore goes out one cycle after reset release (matching the existing chip-enable startup).
- Issue condition (combinational): issue = run_q & !flush_i & !branch_flag_i & (count + pending < DEPTH).
  - imem_ce_o = issue; imem_addr_o = pc.
- On issue:
  - pending<=1, req_pc<=pc.
  - pc<=redir_valid ? redir_target : pc+INST_BYTES (mod 2^ADDR_W, wraps silently); redir_valid<=0.
  - If no issue, pending<=0.
- Response: when pending=1 and not squashed this cycle, push {req_pc, imem_rdata_i}.
  - Push and pop may occur in the same cycle.
  - The credit rule guarantees no push when full; overflow is a design error (assertion).
- Flush (flush_i=1), regardless of every other input:
  - Queue cleared, pending response dropped, redir_valid<=0, pc<=new_pc_i, no issue.
  - id_valid_o=0 on the next cycle.
- Branch (branch_flag_i=1, flush_i=0); the pop of the branch itself occurs normally.
  - DELAY_SLOT=0: clear queue, drop pending, pc<=branch_target_i.
  - DELAY_SLOT=1, at least one entry remains after the pop: keep only the oldest remaining entry (the delay slot), drop the rest and the pending response, pc<=branch_target_i.
  - DELAY_SLOT=1, queue empty after pop, pending=1: keep that response (pushed as the delay slot), pc<=branch_target_i.
  - DELAY_SLOT=1, queue empty and pending=0: redir_valid<=1, redir_target<=branch_target_i. The next issue fetches pc (the delay slot), then pc<=target.
- A branch while redir_valid=1 is a protocol error (ID cannot pop a branch in that state).
- count is a DEPTH-wide saturating-free counter, log2(DEPTH)+1 bits. Read/write pointers wrap modulo DEPTH.

Decomposition:
- Shared defines file: RESET_VECTOR default, ADDR_W/DATA_W defaults, INST_BYTES, enable/disable and branch constants already used by the pipeline.
- One sub-module, fetch_fifo: DEPTH x (ADDR_W+DATA_W) synchronous show-ahead FIFO with push, pop, clear_all, keep_head (truncate to the oldest entry), count output.
- PC, credit, squash and redirect logic live in pc_fetch_queue.

Test Plan:
- Reset release, id_ready_i=1, imem returns addr-derived data:
  - First imem_ce_o one cycle after release at 0x30000000, then 0x30000004, ...
  - id_pc_o sequence 0x30000000, 0x30000004, ... one word per cycle after a 2-cycle fill.
- id_ready_i=0 for 10 cycles:
  - Exactly DEPTH=4 words queued, imem_ce_o=0 once count+pending=4, no loss or duplication.
  - Release ready: in-order drain, then fetch resumes.
- Queue holds 0x100..0x10C, ID pops 0x100 with branch_flag_i=1, target 0x200, DELAY_SLOT=1:
  - Next heads are 0x104 then 0x200; 0x108/0x10C never delivered.
- Same stimulus with DELAY_SLOT=0:
  - Next head is 0x200.
- Branch popped with queue empty and pending=0, pc=0x104:
  - Next fetch 0x104, following fetch 0x200.
- flush_i=1, new_pc_i=0x80000180, simultaneous with branch_flag_i, pending response and full queue:
  - Flush wins; id_valid_o=0 next cycle; next fetch 0x80000180.
- rst=0 asserted mid-stream for one cycle:
  - All outputs at reset values; restart at RESET_VECTOR; stale response not pushed.
